alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shifter.sv | 66 ++++++
 rtl/alu_exec.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, FSM state type and opcode helpers
// Shared by alu_exec, alu_shifter and the ALU control decoder.
// Optional feature macro used by importers: ALU_EXEC_BARREL_SHIFT_EN.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_SRC2 = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

    // Codes above SRC2 (11..15) are unassigned.
    function automatic logic is_legal_op(input logic [3:0] code);
        return code <= ALU_SRC2;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - serial one-bit-per-cycle shifter datapath for alu_exec
// Ports: clk, rst_n (async active-low); load_i captures data_i/ctrl_i/shamt_i;
// step_i advances one bit; next_o is the one-bit-shifted value of the current
// operand (data_i while not stepping, the held operand while stepping);
// last_o flags that the next step completes the shift.
import alu_pkg::*;

module alu_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  logic [3:0]      ctrl_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [SHW-1:0]  shamt_i,
    output logic [XLEN-1:0] next_o,
    output logic            last_o
);

    logic [XLEN-1:0] data_q;
    logic [SHW-1:0]  cnt_q;
    logic            left_q;
    logic            fill_q;

    logic [XLEN-1:0] cur;
    logic            left_c;
    logic            fill_c;

    // The first shift happens on the load cycle itself, so a shift by N
    // needs only N-1 further steps and finishes in N cycles overall.
    always_comb begin
        if (step_i) begin
            cur    = data_q;
            left_c = left_q;
            fill_c = fill_q;
        end else begin
            cur    = data_i;
            left_c = (ctrl_i == ALU_SLL);
            fill_c = (ctrl_i == ALU_SRA) & data_i[XLEN-1];
        end
        next_o = left_c ? {cur[XLEN-2:0], 1'b0} : {fill_c, cur[XLEN-1:1]};
    end

    assign last_o = (cnt_q == SHW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            left_q <= 1'b0;
            fill_q <= 1'b0;
        end else if (load_i) begin
            data_q <= next_o;
            cnt_q  <= shamt_i - SHW'(1);
            left_q <= left_c;
            fill_q <= fill_c;
        end else if (step_i) begin
            data_q <= next_o;
            cnt_q  <= cnt_q - SHW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - handshaked ALU execute stage with IDLE/SHIFT/DONE FSM
// Ports: clk, rst_n (async active-low); in_valid/in_ready, alu_ctrl, src1,
// src2 operation input; out_valid/out_ready, result, zero, illegal output.
// Macro ALU_EXEC_BARREL_SHIFT_EN: single-cycle barrel shifts instead of the
// serial alu_shifter.
import alu_pkg::*;

module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    alu_state_e      state_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;

    logic            accept;
    logic            go_shift;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign shamt    = src2[SHW-1:0];

`ifndef ALU_EXEC_BARREL_SHIFT_EN
    logic [XLEN-1:0] sh_next;
    logic            sh_last;

    // Shifts of 0 or 1 resolve on the accept cycle; only longer ones walk SHIFT.
    assign go_shift = is_shift_op(alu_ctrl) && (shamt > SHW'(1));

    alu_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept & go_shift),
        .step_i  (state_q == ST_SHIFT),
        .ctrl_i  (alu_ctrl),
        .data_i  (src1),
        .shamt_i (shamt),
        .next_o  (sh_next),
        .last_o  (sh_last)
    );
`else
    assign go_shift = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_ADD:  alu_res = src1 + src2;
            ALU_SUB:  alu_res = src1 - src2;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
            ALU_XOR:  alu_res = src1 ^ src2;
            ALU_OR:   alu_res = src1 | src2;
            ALU_AND:  alu_res = src1 & src2;
            ALU_SRC2: alu_res = src2;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
            ALU_SLL:  alu_res = src1 << shamt;
            ALU_SRL:  alu_res = src1 >> shamt;
            ALU_SRA:  alu_res = $signed(src1) >>> shamt;
`else
            ALU_SLL, ALU_SRL, ALU_SRA:
                      alu_res = (shamt == '0) ? src1 : sh_next;
`endif
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (go_shift) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            illegal_q   <= !is_legal_op(alu_ctrl);
                        end
                    end
                end
                ST_SHIFT: begin
`ifdef ALU_EXEC_BARREL_SHIFT_EN
                    state_q <= ST_IDLE;
`else
                    if (sh_last) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= sh_next;
                        zero_q      <= (sh_next == '0);
                        illegal_q   <= 1'b0;
                    end
`endif
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule
